// File: rtl/spi_cmd_sequencer.sv
// Command/data byte FIFO feeding the SPI master byte engine, one byte per handshake,
// with an inter-byte gap and a per-byte timeout against a stuck master.
module spi_cmd_sequencer #(
   parameter int DEPTH          = 16,
   parameter int AW             = 4,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 8192
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic          wr_dc,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic          spi_dc,
   output logic [7:0]    spi_data_out,
   output logic          spi_send,
   input  logic          spi_send_done,
   output logic          busy,
   output logic          overflow,
   output logic          timeout_err,
   input  logic          clr_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int LW = AW + 1;
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_LOW, S_GAP} state_t;

   logic [8:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          r_overflow;
   logic          r_timeout_err;
   logic          r_done_s1;
   logic          r_done_s2;
   logic          r_done_d;
   state_t        r_state;
   logic [TW-1:0] r_tmr;
   logic [GW-1:0] r_gcnt;
   logic          r_send;
   logic          r_dc;
   logic [7:0]    r_data;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_load;
   logic          w_timeout_set;
   logic          w_done_rise;
   logic [8:0]    w_head;
   state_t        w_state_next;
   logic [TW-1:0] w_tmr_next;
   logic [GW-1:0] w_gcnt_next;
   logic          w_send_next;

   assign w_full      = (r_level == LVL_FULL);
   assign w_empty     = (r_level == '0);
   assign w_push      = wr_en && !w_full;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_done_rise = r_done_s2 && !r_done_d;

   // Storage has no reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {wr_dc, wr_data};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (!w_push && w_pop) begin
            r_level <= r_level - 1'b1;
         end
      end
   end

   // A fresh error in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         if (wr_en && w_full) begin
            r_overflow <= 1'b1;
         end else if (clr_err) begin
            r_overflow <= 1'b0;
         end
         if (w_timeout_set) begin
            r_timeout_err <= 1'b1;
         end else if (clr_err) begin
            r_timeout_err <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_done_s1 <= 1'b0;
         r_done_s2 <= 1'b0;
         r_done_d  <= 1'b0;
      end else begin
         r_done_s1 <= spi_send_done;
         r_done_s2 <= r_done_s1;
         r_done_d  <= r_done_s2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_tmr   <= '0;
         r_gcnt  <= '0;
         r_send  <= 1'b0;
         r_dc    <= 1'b0;
         r_data  <= 8'h00;
      end else begin
         r_state <= w_state_next;
         r_tmr   <= w_tmr_next;
         r_gcnt  <= w_gcnt_next;
         r_send  <= w_send_next;
         if (w_load) begin
            r_dc   <= w_head[8];
            r_data <= w_head[7:0];
         end
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_tmr_next    = r_tmr;
      w_gcnt_next   = r_gcnt;
      w_send_next   = r_send;
      w_load        = 1'b0;
      w_pop         = 1'b0;
      w_timeout_set = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_empty && !r_done_s2) begin
               w_load       = 1'b1;
               w_send_next  = 1'b1;
               w_tmr_next   = '0;
               w_state_next = S_SEND;
            end
         end
         S_SEND: begin
            w_tmr_next = r_tmr + 1'b1;
            if (w_done_rise) begin
               w_send_next  = 1'b0;
               w_pop        = 1'b1;
               w_state_next = S_WAIT_LOW;
            end else if (r_tmr == TMR_LAST) begin
               w_send_next   = 1'b0;
               w_pop         = 1'b1;
               w_timeout_set = 1'b1;
               w_state_next  = S_WAIT_LOW;
            end
         end
         S_WAIT_LOW: begin
            // The master's done is long; wait for it to fall before the gap starts.
            if (!r_done_s2) begin
               w_gcnt_next  = '0;
               w_state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            w_gcnt_next = r_gcnt + 1'b1;
            if (r_gcnt == GAP_LAST) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign full         = w_full;
   assign empty        = w_empty;
   assign level        = r_level;
   assign spi_dc       = r_dc;
   assign spi_data_out = r_data;
   assign spi_send     = r_send;
   assign busy         = (r_state != S_IDLE) || !w_empty;
   assign overflow     = r_overflow;
   assign timeout_err  = r_timeout_err;

endmodule
